// File: rtl/alu_checker.sv
// alu_checker: scoreboard for a 32-bit ALU with a fixed result latency.
// Each accepted command's expected result is computed on entry and travels
// down an LAT-deep pipeline. When it reaches the end, it is compared with the
// ALU output `out` sampled in that same cycle.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en, a, b, s     command valid, operands, opcode
//   out             ALU result under check
//   pass_cnt        saturating count of matching results
//   fail_cnt        saturating count of mismatching results
//   err             sticky first-mismatch flag
//   err_op          opcode captured at the first mismatch
//   err_exp         expected value captured at the first mismatch
//   err_got         out value captured at the first mismatch
//   busy            at least one command in flight
module alu_checker #(
    parameter int unsigned LAT   = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    input  logic [2:0]       s,
    input  logic [31:0]      out,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err,
    output logic [2:0]       err_op,
    output logic [31:0]      err_exp,
    output logic [31:0]      err_got,
    output logic             busy
);

    localparam int unsigned DW = 32;
    localparam int unsigned OW = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t         state, state_next;
    logic [LAT-1:0] vld, vld_next;
    logic [OW-1:0]  op_q  [LAT];
    logic [DW-1:0]  exp_q [LAT];
    logic [DW-1:0]  exp_c;
    logic           retire, mismatch, match;

    // Reference ALU; carries and borrows fall off the top.
    always_comb begin
        exp_c = '0;
        case (s)
            3'b000:  exp_c = a + b;
            3'b001:  exp_c = a - b;
            3'b010:  exp_c = a & b;
            3'b011:  exp_c = a | b;
            3'b100:  exp_c = a ^ b;
            3'b101:  exp_c = ~a;
            3'b110:  exp_c = a << 1;
            default: exp_c = a >> 1;
        endcase
    end

    assign retire   = vld[LAT-1];
    assign mismatch = retire && (out != exp_q[LAT-1]);
    assign match    = retire && (out == exp_q[LAT-1]);

    // Valid bits shift every cycle; the shift also handles a retire and a push in the same cycle.
    always_comb begin
        vld_next    = vld << 1;
        vld_next[0] = en;
    end

    // Payload pipeline. It needs no reset because the valid bits qualify every entry.
    always_ff @(posedge clk) begin
        op_q[0]  <= s;
        exp_q[0] <= exp_c;
        for (int unsigned i = 1; i < LAT; i++) begin
            op_q[i]  <= op_q[i-1];
            exp_q[i] <= exp_q[i-1];
        end
    end

    // FSM next state.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (mismatch)
                    state_next = ERR;
                else if (en)
                    state_next = RUN;
            end
            RUN: begin
                if (mismatch)
                    state_next = ERR;
                else if (vld_next == '0)
                    state_next = IDLE;
            end
            ERR:     state_next = ERR;
            default: state_next = IDLE;
        endcase
    end

    // State, valid bits, counters and first-error capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            vld      <= '0;
            busy     <= 1'b0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            err      <= 1'b0;
            err_op   <= '0;
            err_exp  <= '0;
            err_got  <= '0;
        end else begin
            state <= state_next;
            vld   <= vld_next;
            busy  <= |vld_next;
            err   <= (state_next == ERR);
            if (match && (pass_cnt != '1))
                pass_cnt <= pass_cnt + CNT_W'(1);
            if (mismatch && (fail_cnt != '1))
                fail_cnt <= fail_cnt + CNT_W'(1);
            if (mismatch && (state != ERR)) begin
                err_op  <= op_q[LAT-1];
                err_exp <= exp_q[LAT-1];
                err_got <= out;
            end
        end
    end

endmodule

// File: tb/tb_alu_checker.sv
// Testbench for alu_checker. It uses three instances:
//   u1: LAT=1, CNT_W=16 for the opcode sweep, fault injection and wrap arithmetic.
//   u2: LAT=2 for the en gap pattern.
//   u3: LAT=3, CNT_W=4 for the mid-flight reset and counter saturation.
// A scoreboard queue holds the outcome each u1 command should produce.
module tb_alu_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] a, b;
    logic [2:0]  s;

    logic        rst1, en1, err1, busy1;
    logic [31:0] out1, eexp1, egot1;
    logic [15:0] pass1, fail1;
    logic [2:0]  eop1;

    logic        rst2, en2, err2, busy2;
    logic [31:0] out2, eexp2, egot2;
    logic [15:0] pass2, fail2;
    logic [2:0]  eop2;

    logic        rst3, en3, err3, busy3;
    logic [31:0] out3, eexp3, egot3;
    logic [3:0]  pass3, fail3;
    logic [2:0]  eop3;

    alu_checker #(.LAT(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst1), .en(en1), .a(a), .b(b), .s(s), .out(out1),
        .pass_cnt(pass1), .fail_cnt(fail1), .err(err1), .err_op(eop1),
        .err_exp(eexp1), .err_got(egot1), .busy(busy1));

    alu_checker #(.LAT(2), .CNT_W(16)) u2 (
        .clk(clk), .rst(rst2), .en(en2), .a(a), .b(b), .s(s), .out(out2),
        .pass_cnt(pass2), .fail_cnt(fail2), .err(err2), .err_op(eop2),
        .err_exp(eexp2), .err_got(egot2), .busy(busy2));

    alu_checker #(.LAT(3), .CNT_W(4)) u3 (
        .clk(clk), .rst(rst3), .en(en3), .a(a), .b(b), .s(s), .out(out3),
        .pass_cnt(pass3), .fail_cnt(fail3), .err(err3), .err_op(eop3),
        .err_exp(eexp3), .err_got(egot3), .busy(busy3));

    int          checks   = 0;
    int          failures = 0;
    bit          sb_q[$];
    bit          mon_on   = 1'b0;
    logic [15:0] prev_p, prev_f;
    logic [31:0] exp_t [8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
        end
    endtask

    task automatic sb_pop(input bit got);
        bit e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected got=%0d exp=none", got);
        end else begin
            e = sb_q.pop_front();
            chk("sb_outcome", 32'(got), 32'(e));
        end
    endtask

    // Monitor: each u1 counter step consumes one scoreboard entry (1 = pass, 0 = fail).
    always @(negedge clk) begin
        if (mon_on) begin
            if (pass1 == prev_p + 16'd1) sb_pop(1'b1);
            if (fail1 == prev_f + 16'd1) sb_pop(1'b0);
            prev_p = pass1;
            prev_f = fail1;
        end
    end

    // Apply inputs just after a falling edge, then return at the next falling edge.
    task automatic d1(input bit e, input logic [31:0] ia, input logic [31:0] ib,
                      input logic [2:0] is, input logic [31:0] o, input bit pf);
        en1 = e; a = ia; b = ib; s = is; out1 = o;
        if (e) sb_q.push_back(pf);
        @(negedge clk);
    endtask

    task automatic d2(input bit e, input logic [31:0] ia, input logic [31:0] ib,
                      input logic [2:0] is, input logic [31:0] o);
        en2 = e; a = ia; b = ib; s = is; out2 = o;
        @(negedge clk);
    endtask

    task automatic d3(input bit e, input logic [31:0] ia, input logic [31:0] ib,
                      input logic [2:0] is, input logic [31:0] o);
        en3 = e; a = ia; b = ib; s = is; out3 = o;
        @(negedge clk);
    endtask

    task automatic rst1_pulse();
        rst1 = 1'b1; en1 = 1'b0;
        @(negedge clk);
        rst1 = 1'b0;
    endtask

    // Opcode sweep with a=0x5F, b=0x0A. On the retire of opcode fault_idx,
    // out is forced to 0x54; pass -1 for no fault.
    task automatic sweep(input int fault_idx);
        logic [31:0] o;
        for (int i = 0; i < 9; i++) begin
            if (i == 0)                o = 32'hDEAD_0000;
            else if (i - 1 == fault_idx) o = 32'h54;
            else                       o = exp_t[i-1];
            d1(i < 8, 32'h5F, 32'h0A, 3'(i), o, i != fault_idx);
            if (i == 3) chk("sweep_busy_mid", 32'(busy1), 32'd1);
        end
    endtask

    initial begin
        exp_t[0] = 32'h69;       exp_t[1] = 32'h55;
        exp_t[2] = 32'h0A;       exp_t[3] = 32'h5F;
        exp_t[4] = 32'h55;       exp_t[5] = 32'hFFFF_FFA0;
        exp_t[6] = 32'hBE;       exp_t[7] = 32'h2F;

        rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
        en1 = 1'b0;  en2 = 1'b0;  en3 = 1'b0;
        a = '0; b = '0; s = '0;
        out1 = '0; out2 = '0; out3 = '0;
        repeat (2) @(negedge clk);
        rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;

        // Reset state
        chk("rst_pass", 32'(pass1), 32'd0);
        chk("rst_fail", 32'(fail1), 32'd0);
        chk("rst_err",  32'(err1),  32'd0);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_eexp", eexp1,      32'd0);
        prev_p = pass1; prev_f = fail1; mon_on = 1'b1;

        // Clean opcode sweep
        sweep(-1);
        chk("sweep_pass", 32'(pass1), 32'd8);
        chk("sweep_fail", 32'(fail1), 32'd0);
        chk("sweep_err",  32'(err1),  32'd0);
        chk("sweep_busy", 32'(busy1), 32'd0);

        // Fault injected on the opcode 001 retire
        rst1_pulse();
        sweep(1);
        chk("fault_err",  32'(err1),  32'd1);
        chk("fault_op",   32'(eop1),  32'd1);
        chk("fault_exp",  eexp1,      32'h55);
        chk("fault_got",  egot1,      32'h54);
        chk("fault_pass", 32'(pass1), 32'd7);
        chk("fault_fail", 32'(fail1), 32'd1);
        // Second fault: the first-error fields must hold
        d1(1'b1, 32'd1, 32'd2, 3'b000, 32'hDEAD_0001, 1'b0);
        d1(1'b0, 32'd0, 32'd0, 3'b000, 32'h0, 1'b0);
        chk("fault2_fail", 32'(fail1), 32'd2);
        chk("fault2_op",   32'(eop1),  32'd1);
        chk("fault2_exp",  eexp1,      32'h55);
        chk("fault2_got",  egot1,      32'h54);
        chk("fault2_err",  32'(err1),  32'd1);

        // Reset out of ERR clears everything
        rst1_pulse();
        chk("errrst_err",  32'(err1),  32'd0);
        chk("errrst_op",   32'(eop1),  32'd0);
        chk("errrst_got",  egot1,      32'd0);
        chk("errrst_fail", 32'(fail1), 32'd0);

        // Wrap arithmetic
        d1(1'b1, 32'hFFFF_FFFF, 32'd1, 3'b000, 32'hDEAD_0002, 1'b1);
        d1(1'b1, 32'h0,         32'd1, 3'b001, 32'h0,         1'b1);
        d1(1'b0, 32'h0,         32'd0, 3'b000, 32'hFFFF_FFFF, 1'b0);
        chk("wrap_pass", 32'(pass1), 32'd2);
        chk("wrap_fail", 32'(fail1), 32'd0);
        chk("wrap_err",  32'(err1),  32'd0);

        // Gaps with LAT=2: en pattern 1,0,1 and garbage in the idle retire slot
        d2(1'b1, 32'd3, 32'd4, 3'b000, 32'hBAD0_0000);
        d2(1'b0, 32'd0, 32'd0, 3'b000, 32'hBAD0_0001);
        chk("gap_early_pass", 32'(pass2), 32'd0);
        chk("gap_early_fail", 32'(fail2), 32'd0);
        d2(1'b1, 32'd8, 32'd1, 3'b001, 32'd7);
        d2(1'b0, 32'd0, 32'd0, 3'b000, 32'hDEAD_BEEF);
        chk("gap_idle_pass", 32'(pass2), 32'd1);
        chk("gap_idle_fail", 32'(fail2), 32'd0);
        d2(1'b0, 32'd0, 32'd0, 3'b000, 32'd7);
        d2(1'b0, 32'd0, 32'd0, 3'b000, 32'hBAD0_0002);
        chk("gap_pass", 32'(pass2), 32'd2);
        chk("gap_fail", 32'(fail2), 32'd0);
        chk("gap_busy", 32'(busy2), 32'd0);
        chk("gap_err",  32'(err2),  32'd0);

        // Mid-flight reset with LAT=3: rst in the first entry's retire cycle
        d3(1'b1, 32'd1, 32'd1, 3'b000, 32'hBAD0_0003);
        d3(1'b1, 32'd2, 32'd2, 3'b000, 32'hBAD0_0004);
        d3(1'b1, 32'd3, 32'd3, 3'b000, 32'hBAD0_0005);
        chk("mid_busy_pre", 32'(busy3), 32'd1);
        rst3 = 1'b1; en3 = 1'b0; out3 = 32'd2;
        @(negedge clk);
        rst3 = 1'b0;
        chk("mid_pass", 32'(pass3), 32'd0);
        chk("mid_fail", 32'(fail3), 32'd0);
        chk("mid_busy", 32'(busy3), 32'd0);
        chk("mid_err",  32'(err3),  32'd0);
        d3(1'b0, 32'd0, 32'd0, 3'b000, 32'd4);
        d3(1'b0, 32'd0, 32'd0, 3'b000, 32'd6);
        chk("mid_flush_pass", 32'(pass3), 32'd0);
        chk("mid_flush_fail", 32'(fail3), 32'd0);

        // Saturation with CNT_W=4: 20 back-to-back matching commands
        for (int j = 0; j < 23; j++) begin
            d3(j < 20, 32'(j), 32'd1, 3'b000, (j >= 3) ? 32'(j - 2) : 32'hBAD0_0006);
            if (j == 16) chk("sat_pre", 32'(pass3), 32'd14);
        end
        chk("sat_pass", 32'(pass3), 32'd15);
        chk("sat_fail", 32'(fail3), 32'd0);
        chk("sat_busy", 32'(busy3), 32'd0);

        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_checker.md
ALU_CHECKER -- requirements
Module: alu_checker

Interface
REQ-001 Parameter LAT, default 1: ALU result latency in clk cycles from operand sample to valid `out`; legal range 1..4.
REQ-002 Parameter CNT_W, default 16: width of pass/fail counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  a, b and s carry a valid ALU command this cycle.
REQ-006 a  input  32  operand A presented to the ALU.
REQ-007 b  input  32  operand B presented to the ALU.
REQ-008 s  input  3  ALU opcode.
REQ-009 out  input  32  ALU result under check.
REQ-010 pass_cnt  output  CNT_W  number of matching results.
REQ-011 fail_cnt  output  CNT_W  number of mismatching results.
REQ-012 err  output  1  sticky flag; set on the first mismatch.
REQ-013 err_op  output  3  opcode of the first mismatch.
REQ-014 err_exp  output  32  expected value of the first mismatch.
REQ-015 err_got  output  32  `out` value of the first mismatch.
REQ-016 busy  output  1  at least one command is in flight in the check pipeline.

Function
REQ-017 The expected result SHALL be computed on 32 bits with carries and borrows discarded: 000 a+b; 001 a-b; 010 a&b; 011 a|b; 100 a^b; 101 ~a; 110 a<<1; 111 a>>1 (logical).
REQ-018 On each cycle with en=1, the block SHALL push {valid, s, expected} into an LAT-deep shift pipeline; when en=0 it SHALL push valid=0.
REQ-019 When a valid entry leaves the pipeline (LAT cycles after its en cycle), the block SHALL compare `out` sampled in that same cycle against the stored expected value.
REQ-020 On a match, pass_cnt SHALL increment by 1 on the next edge.
REQ-021 On a mismatch, fail_cnt SHALL increment by 1 on the next edge.
REQ-022 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-023 FSM states:
- IDLE: pipeline empty, err=0.
- RUN: at least one valid entry, err=0.
- ERR: err=1.
REQ-024 FSM transitions:
- IDLE->RUN on en=1.
- RUN->IDLE when the last valid entry retires and en=0.
- IDLE/RUN->ERR on any mismatch.
- ERR is left only by rst.
REQ-025 In ERR, checking and counting SHALL continue, but err_op, err_exp and err_got SHALL hold the first-mismatch values.
REQ-026 busy SHALL equal the OR of all pipeline valid bits.
REQ-027 Back-to-back en=1 SHALL be accepted every cycle with no stall; throughput is one check per cycle.
REQ-028 A retire and a new push in the same cycle SHALL both take effect.
REQ-029 `out` SHALL be ignored in cycles with no valid retiring entry.

Reset
REQ-030 On a clk edge with rst=1, the block SHALL clear:
- all pipeline valid bits, flushing in-flight commands uncounted;
- pass_cnt and fail_cnt to 0;
- err to 0, err_op to 0, err_exp to 0, err_got to 0;
- busy to 0;
- the FSM to IDLE.
REQ-031 rst SHALL take priority over en and over a simultaneous retire/compare in the same cycle.
REQ-032 Outputs SHALL be undefined only before the first rst edge; a bench SHALL assert rst for at least 1 cycle first.

Verification
REQ-033 Opcode sweep, LAT=1: a=0x5F, b=0x0A, s=000..111 on consecutive cycles, correct ALU -> expected values 0x69, 0x55, 0x0A, 0x5F, 0x55, 0xFFFFFFA0, 0xBE, 0x2F; pass_cnt=8, fail_cnt=0, err=0, busy=0 one cycle after the last retire.
REQ-034 Fault injection: same sweep, but `out` forced to 0x54 on the s=001 retire -> err=1, err_op=001, err_exp=0x55, err_got=0x54; final pass_cnt=7, fail_cnt=1; a second injected fault leaves the err_* fields unchanged and gives fail_cnt=2.
REQ-035 Wrap arithmetic: a=0xFFFFFFFF, b=1, s=000 -> expected 0; a=0, b=1, s=001 -> expected 0xFFFFFFFF; both pass.
REQ-036 Mid-flight reset, LAT=3: three en cycles, then rst pulsed in the cycle the first entry would retire -> counters 0, busy=0, FSM IDLE, no count for flushed entries.
REQ-037 Saturation, CNT_W=4: 20 matching commands -> pass_cnt=15 (holds).
REQ-038 Gaps: en pattern 1,0,1 with LAT=2 -> exactly 2 compares; `out`=garbage in the idle retire slot causes no count change.
